// File: rtl/adc_period_detector.sv
// adc_period_detector
//   Issues the periodic sample request to the XADC aux-channel-6 stage and
//   measures the period of the returned waveform. The 12-bit code goes through
//   a hysteresis comparator. The bench counts samples between rising crossings,
//   and averages 2^AVG_LOG2 periods into period_out.
//
//   Optional build macro: PERIOD_GLITCH_REJECT_EN
//     When defined, a rising crossing less than MIN_PERIOD samples after the
//     previous accepted one is not treated as a period boundary.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   adc_ena       out  one-cycle sample request, every SAMPLE_DIV clocks
//   sample_valid  in   one-cycle strobe marking a new sample
//   sample_in     in   16-bit ADC word, code in bits [15:4]
//   period_out    out  averaged period in samples (holds between updates)
//   period_valid  out  one-cycle pulse when period_out updates
//   signal_lost   out  high while no valid periodic signal is present
module adc_period_detector #(
  parameter int SAMPLE_DIV = 2000,
  parameter int MID        = 2048,
  parameter int HYST       = 64,
  parameter int PERIOD_W   = 16,
  parameter int AVG_LOG2   = 2,
  parameter int TIMEOUT    = 4000,
  parameter int MIN_PERIOD = 20
) (
  input  logic                clk,
  input  logic                rst,
  output logic                adc_ena,
  input  logic                sample_valid,
  input  logic [15:0]         sample_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                signal_lost
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ACC_W  = PERIOD_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [12:0]         HI_TH     = 13'(MID + HYST);
  localparam logic [12:0]         LO_TH     = 13'(MID - HYST);
  localparam logic [NPER_W-1:0]   NPER_FULL = NPER_W'(1 << AVG_LOG2);
  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

`ifdef PERIOD_GLITCH_REJECT_EN
  localparam logic [PERIOD_W-1:0] MIN_C = PERIOD_W'(MIN_PERIOD);
`else
  // cnt is always >= 1 in MEASURE, so a threshold of 1 accepts every edge.
  localparam logic [PERIOD_W-1:0] MIN_C = PERIOD_W'(1 + 0 * MIN_PERIOD);
`endif

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MEASURE = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [DIV_W-1:0]     div_r, div_nxt_s;
  logic                 adc_ena_r;
  logic                 cmp_r, cmp_nxt_s;
  logic [PERIOD_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [ACC_W-1:0]     acc_r, acc_nxt_s, acc_sum_s;
  logic [NPER_W-1:0]    nper_r, nper_nxt_s, nper_inc_s;
  logic [PERIOD_W-1:0]  period_out_r, period_out_nxt_s;
  logic                 period_valid_r, period_valid_nxt_s;
  logic                 signal_lost_r, signal_lost_nxt_s;
  logic [12:0]          code_s;
  logic                 re_s, accept_s;
  logic                 unused_low_s;

  assign code_s       = {1'b0, sample_in[15:4]};
  assign unused_low_s = ^sample_in[3:0];

  assign div_nxt_s  = (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
  assign cnt_inc_s  = cnt_r + PERIOD_W'(1);
  assign acc_sum_s  = acc_r + ACC_W'(cnt_r);
  assign nper_inc_s = nper_r + NPER_W'(1);
  assign accept_s   = (cnt_r >= MIN_C);

  // Free-running divider; adc_ena is registered so it is high while div == SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r     <= {DIV_W{1'b0}};
      adc_ena_r <= 1'b0;
    end else begin
      div_r     <= div_nxt_s;
      adc_ena_r <= (div_nxt_s == DIV_LAST);
    end
  end

  assign adc_ena = adc_ena_r;

  // Hysteresis comparator next state and rising-edge detect.
  always_comb begin
    cmp_nxt_s = cmp_r;
    if (!sample_valid) begin
      cmp_nxt_s = cmp_r;
    end else if (!cmp_r) begin
      cmp_nxt_s = (code_s >= HI_TH);
    end else begin
      cmp_nxt_s = !(code_s <= LO_TH);
    end
  end

  assign re_s = sample_valid && !cmp_r && cmp_nxt_s;

  // Next-state and datapath for period measurement and averaging.
  always_comb begin
    state_nxt_s        = state_r;
    cnt_nxt_s          = cnt_r;
    acc_nxt_s          = acc_r;
    nper_nxt_s         = nper_r;
    period_out_nxt_s   = period_out_r;
    period_valid_nxt_s = 1'b0;
    signal_lost_nxt_s  = signal_lost_r;
    if (sample_valid) begin
      case (state_r)
        S_IDLE: begin
          if (re_s) begin
            cnt_nxt_s   = PERIOD_W'(1);
            state_nxt_s = S_MEASURE;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_MEASURE: begin
          if (re_s && accept_s) begin
            cnt_nxt_s = PERIOD_W'(1);
            if (nper_inc_s == NPER_FULL) begin
              // Last period of the group: publish the truncated mean.
              period_out_nxt_s   = PERIOD_W'(acc_sum_s >> AVG_LOG2);
              period_valid_nxt_s = 1'b1;
              signal_lost_nxt_s  = 1'b0;
              acc_nxt_s          = {ACC_W{1'b0}};
              nper_nxt_s         = {NPER_W{1'b0}};
            end else begin
              acc_nxt_s  = acc_sum_s;
              nper_nxt_s = nper_inc_s;
            end
          end else if (cnt_inc_s == TIMEOUT_C) begin
            // No crossing for TIMEOUT samples: drop the partial average.
            state_nxt_s       = S_IDLE;
            cnt_nxt_s         = {PERIOD_W{1'b0}};
            acc_nxt_s         = {ACC_W{1'b0}};
            nper_nxt_s        = {NPER_W{1'b0}};
            signal_lost_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = {PERIOD_W{1'b0}};
          acc_nxt_s   = {ACC_W{1'b0}};
          nper_nxt_s  = {NPER_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, comparator and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      cmp_r          <= 1'b0;
      cnt_r          <= {PERIOD_W{1'b0}};
      acc_r          <= {ACC_W{1'b0}};
      nper_r         <= {NPER_W{1'b0}};
      period_out_r   <= {PERIOD_W{1'b0}};
      period_valid_r <= 1'b0;
      signal_lost_r  <= 1'b1;
    end else begin
      state_r        <= state_nxt_s;
      cmp_r          <= cmp_nxt_s;
      cnt_r          <= cnt_nxt_s;
      acc_r          <= acc_nxt_s;
      nper_r         <= nper_nxt_s;
      period_out_r   <= period_out_nxt_s;
      period_valid_r <= period_valid_nxt_s;
      signal_lost_r  <= signal_lost_nxt_s;
    end
  end

  assign period_out   = period_out_r;
  assign period_valid = period_valid_r;
  assign signal_lost  = signal_lost_r;

endmodule

// File: tb/tb_adc_period_detector.sv
// Directed testbench for adc_period_detector (SAMPLE_DIV=4, other defaults).
module tb_adc_period_detector;

  localparam logic [15:0] HI = 16'hFFF0;
  localparam logic [15:0] LO = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_ena;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic [15:0] period_out;
  logic        period_valid;
  logic        signal_lost;

  int n_checks = 0;
  int n_pass   = 0;
  int pv_cycles = 0;
  logic [15:0] pv_last = 16'h0000;

  adc_period_detector #(.SAMPLE_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_ena      (adc_ena),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .signal_lost  (signal_lost)
  );

  always #5 clk = ~clk;

  // Count period_valid cycles and record the value published with each.
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      pv_cycles <= pv_cycles + 1;
      pv_last   <= period_out;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [15:0] v);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = v;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wave_from(input int per, input int start);
    for (int i = start; i < per; i++) drive((i < per / 2) ? HI : LO);
  endtask

  task automatic wave(input int per);
    wave_from(per, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({period_valid, signal_lost, period_out} !== {1'b0, 1'b1, 16'd0})
      $display("FAIL reset_outputs: pv=%b lost=%b pout=%0d, expected pv=0 lost=1 pout=0",
               period_valid, signal_lost, period_out);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (adc_ena !== ((i % 4) == 3))
        $display("FAIL adc_ena_cycle%0d: got %b expected %b", i, adc_ena, ((i % 4) == 3));
      else n_pass++;
    end
  endtask

  task automatic test_square();
    int base;
    do_reset();
    base = pv_cycles;
    for (int w = 0; w < 4; w++) wave(100);
    settle();
    n_checks++;
    if ((pv_cycles - base) !== 0 || signal_lost !== 1'b1)
      $display("FAIL square_before_lock: pv_cycles=%0d lost=%b, expected 0 and 1",
               pv_cycles - base, signal_lost);
    else n_pass++;
    drive(HI);
    n_checks++;
    if ({period_valid, signal_lost, period_out} !== {1'b1, 1'b0, 16'd100})
      $display("FAIL square_lock: pv=%b lost=%b pout=%0d, expected pv=1 lost=0 pout=100",
               period_valid, signal_lost, period_out);
    else n_pass++;
    drive(HI);
    n_checks++;
    if (period_valid !== 1'b0)
      $display("FAIL square_pulse_width: pv=%b expected 0", period_valid);
    else n_pass++;
    wave_from(100, 2);
    for (int w = 0; w < 3; w++) wave(100);
    drive(HI);
    n_checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd100)
      $display("FAIL square_repeat: pv=%b pout=%0d, expected pv=1 pout=100", period_valid, period_out);
    else n_pass++;
    wave_from(100, 1);
    settle();
    n_checks++;
    if ((pv_cycles - base) !== 2)
      $display("FAIL square_pulse_count: got %0d expected 2", pv_cycles - base);
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    int base;
    logic [11:0] code;
    do_reset();
    base = pv_cycles;
    for (int i = 0; i < 10000; i++) begin
      code = 12'(2016 + (i % 64));
      drive({code, 4'h0});
    end
    settle();
    n_checks++;
    if ((pv_cycles - base) !== 0 || signal_lost !== 1'b1)
      $display("FAIL hysteresis: pv_cycles=%0d lost=%b, expected 0 and 1", pv_cycles - base, signal_lost);
    else n_pass++;
  endtask

  task automatic test_average();
    do_reset();
    wave(98); wave(102); wave(99); wave(101);
    drive(HI);
    n_checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd100)
      $display("FAIL avg_400: pv=%b pout=%0d, expected pv=1 pout=100", period_valid, period_out);
    else n_pass++;
    wave_from(100, 1);
    wave(100); wave(100); wave(103);
    drive(HI);
    n_checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd100)
      $display("FAIL avg_403_trunc: pv=%b pout=%0d, expected pv=1 pout=100", period_valid, period_out);
    else n_pass++;
    wave_from(100, 1);
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    for (int w = 0; w < 5; w++) wave(100);
    for (int i = 0; i < 3999; i++) drive(HI);
    n_checks++;
    if (signal_lost !== 1'b0)
      $display("FAIL timeout_early: lost=%b expected 0 after 3999 samples", signal_lost);
    else n_pass++;
    drive(HI);
    n_checks++;
    if (signal_lost !== 1'b1 || period_out !== 16'd100)
      $display("FAIL timeout_hit: lost=%b pout=%0d, expected lost=1 pout=100 held", signal_lost, period_out);
    else n_pass++;
    for (int i = 0; i < 10; i++) drive(LO);
    base = pv_cycles;
    for (int w = 0; w < 4; w++) wave(100);
    settle();
    n_checks++;
    if ((pv_cycles - base) !== 0 || signal_lost !== 1'b1)
      $display("FAIL timeout_relock_early: pv_cycles=%0d lost=%b, expected 0 and 1",
               pv_cycles - base, signal_lost);
    else n_pass++;
    drive(HI);
    n_checks++;
    if ({period_valid, signal_lost, period_out} !== {1'b1, 1'b0, 16'd100})
      $display("FAIL timeout_relock: pv=%b lost=%b pout=%0d, expected pv=1 lost=0 pout=100",
               period_valid, signal_lost, period_out);
    else n_pass++;
    wave_from(100, 1);
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    wave(60); wave(60); wave(60);
    do_reset();
    base = pv_cycles;
    for (int w = 0; w < 4; w++) wave(100);
    settle();
    n_checks++;
    if ((pv_cycles - base) !== 0)
      $display("FAIL rst_mid_stale: pv_cycles=%0d expected 0", pv_cycles - base);
    else n_pass++;
    drive(HI);
    n_checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd100)
      $display("FAIL rst_mid_value: pv=%b pout=%0d, expected pv=1 pout=100", period_valid, period_out);
    else n_pass++;
    wave_from(100, 1);
  endtask

  task automatic test_glitch();
    int base;
    logic [15:0] exp_p;
`ifdef PERIOD_GLITCH_REJECT_EN
    exp_p = 16'd100;
`else
    exp_p = 16'd75;
`endif
    do_reset();
    base = pv_cycles;
    wave(100); wave(10); wave(90); wave(100); wave(100); wave(100);
    drive(HI);
    settle();
    n_checks++;
    if ((pv_cycles - base) !== 1 || pv_last !== exp_p)
      $display("FAIL glitch: pv_cycles=%0d pout=%0d, expected 1 and %0d", pv_cycles - base, pv_last, exp_p);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_square();
    test_hysteresis();
    test_average();
    test_timeout();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
